// File: rtl/prog_seq_pkg.sv
// Shared definitions for the program sequencer.
//   state_t          : sequencer FSM states
//   DEF_HALT_ADDR    : default program-counter value that marks completion
//   DEF_TIMEOUT_CYCLES : default RUN-cycle budget before forced completion
//   addr_t / start_table_t : program-memory address and per-program entry table
package prog_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_LAUNCH,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [11:0] DEF_HALT_ADDR      = 12'h256;
  localparam logic [15:0] DEF_TIMEOUT_CYCLES = 16'd4000;

  typedef logic [11:0] addr_t;
  typedef addr_t [3:0] start_table_t;

  // Entry 0 ends up in the least significant slot, so table[prog_sel] picks it.
  function automatic start_table_t make_start_table(input addr_t a0, input addr_t a1,
                                                    input addr_t a2, input addr_t a3);
    return {a3, a2, a1, a0};
  endfunction

endpackage

// File: rtl/prog_seq_if.sv
// Bench-side bus of the program sequencer.
//   master : drives req, prog_sel, prog_ctr, halt_inst (bench / fetch+decode side)
//   slave  : drives core_init, start, start_addr, ack, busy, timeout, cycle_count
interface prog_seq_if;
  import prog_seq_pkg::*;

  logic        req;
  logic [1:0]  prog_sel;
  addr_t       prog_ctr;
  logic        halt_inst;
  logic        core_init;
  logic        start;
  addr_t       start_addr;
  logic        ack;
  logic        busy;
  logic        timeout;
  logic [15:0] cycle_count;

  modport master (
    output req, prog_sel, prog_ctr, halt_inst,
    input  core_init, start, start_addr, ack, busy, timeout, cycle_count
  );

  modport slave (
    input  req, prog_sel, prog_ctr, halt_inst,
    output core_init, start, start_addr, ack, busy, timeout, cycle_count
  );

endinterface

// File: rtl/prog_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears the count
//   clr   : synchronous clear (has priority over en)
//   en    : count enable; the count sticks at all-ones
//   count : current count
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && !(&count_reg)) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: on a bench request, resets the datapath for INIT_CYCLES,
// pulses start with the selected entry address, counts RUN cycles until a halt
// (prog_ctr == HALT_ADDR or halt_inst) or the cycle budget runs out, then
// acknowledges until the request is withdrawn.
//   clk    : sole clock
//   init_n : asynchronous active-low reset
//   bus    : prog_seq_if.slave (req/prog_sel/prog_ctr/halt_inst in;
//            core_init/start/start_addr/ack/busy/timeout/cycle_count out)
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter addr_t       HALT_ADDR      = DEF_HALT_ADDR,
  parameter logic [15:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned INIT_CYCLES    = 2,
  parameter addr_t       START_ADDR0    = 12'h000,
  parameter addr_t       START_ADDR1    = 12'h100,
  parameter addr_t       START_ADDR2    = 12'h200,
  parameter addr_t       START_ADDR3    = 12'h300
) (
  input  logic     clk,
  input  logic     init_n,
  prog_seq_if.slave bus
);

  localparam start_table_t START_TABLE =
    make_start_table(START_ADDR0, START_ADDR1, START_ADDR2, START_ADDR3);
  localparam logic [3:0]  INIT_LOAD    = 4'(INIT_CYCLES);
  localparam logic [15:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 16'd1;

  state_t      state_reg, state_next;
  logic [3:0]  init_cnt_reg;
  logic        req_low_reg;   // req was low on the previous edge: arms a new run
  addr_t       start_addr_reg;
  logic        core_init_reg, start_reg, ack_reg, busy_reg, timeout_reg;
  logic        accept, halt_hit, limit_hit, run_en;
  logic [15:0] count;

  assign halt_hit  = (bus.prog_ctr == HALT_ADDR) || bus.halt_inst;
  assign limit_hit = (count == TIMEOUT_LAST);
  assign run_en    = (state_reg == ST_RUN);

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Only a fresh rising request starts a run.
        if (bus.req && req_low_reg) begin
          accept     = 1'b1;
          state_next = ST_INIT;
        end
      end
      ST_INIT: begin
        if (!bus.req)                state_next = ST_IDLE;
        else if (init_cnt_reg == 4'd1) state_next = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        if (!bus.req) state_next = ST_IDLE;
        else          state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!bus.req)                  state_next = ST_IDLE;
        else if (halt_hit || limit_hit) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (!bus.req) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_reg      <= ST_IDLE;
      init_cnt_reg   <= '0;
      req_low_reg    <= 1'b0;
      start_addr_reg <= START_ADDR0;
      core_init_reg  <= 1'b0;
      start_reg      <= 1'b0;
      ack_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      req_low_reg <= ~bus.req;

      if (accept) begin
        init_cnt_reg   <= INIT_LOAD;
        start_addr_reg <= START_TABLE[bus.prog_sel];
      end else if (state_reg == ST_INIT) begin
        init_cnt_reg <= init_cnt_reg - 4'd1;
      end

      // Timeout flags only a budget-forced finish; a simultaneous halt wins.
      if (accept) begin
        timeout_reg <= 1'b0;
      end else if (state_reg == ST_RUN && state_next == ST_DONE) begin
        timeout_reg <= !halt_hit;
      end else if (state_reg == ST_DONE && state_next == ST_IDLE) begin
        timeout_reg <= 1'b0;
      end

      // Outputs are decoded from the next state so they change on the same edge.
      core_init_reg <= (state_next == ST_INIT);
      start_reg     <= (state_next == ST_LAUNCH);
      ack_reg       <= (state_next == ST_DONE);
      busy_reg      <= (state_next != ST_IDLE);
    end
  end

  sat_counter #(.WIDTH(16)) u_cycle_counter (
    .clk   (clk),
    .rst_n (init_n),
    .clr   (accept),
    .en    (run_en),
    .count (count)
  );

  assign bus.core_init   = core_init_reg;
  assign bus.start       = start_reg;
  assign bus.start_addr  = start_addr_reg;
  assign bus.ack         = ack_reg;
  assign bus.busy        = busy_reg;
  assign bus.timeout     = timeout_reg;
  assign bus.cycle_count = count;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: a table of directed runs plus
// randomized runs whose expectations come from a run-level outcome model.
module tb_prog_sequencer;
  import prog_seq_pkg::*;

  localparam int TO     = 100;
  localparam int INIT_N = 2;
  localparam logic [11:0] ADDR_TAB [4] = '{12'h000, 12'h100, 12'h200, 12'h300};

  typedef struct {
    logic [1:0]  sel;
    int          halt_at;   // RUN cycle carrying the halt condition, 0 = none
    bit          use_pc;    // halt via prog_ctr==HALT_ADDR, else halt_inst
    int          abort_at;  // RUN cycle in which req drops, 0 = never
    logic [11:0] exp_addr;
    bit          exp_ack;
    bit          exp_to;
    int          exp_count;
  } vec_t;

  logic clk = 1'b0;
  logic init_n;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  prog_seq_if bus_if();

  prog_sequencer #(
    .HALT_ADDR      (12'h256),
    .TIMEOUT_CYCLES (16'd100),
    .INIT_CYCLES    (2),
    .START_ADDR0    (12'h000),
    .START_ADDR1    (12'h100),
    .START_ADDR2    (12'h200),
    .START_ADDR3    (12'h300)
  ) dut (
    .clk    (clk),
    .init_n (init_n),
    .bus    (bus_if.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [11:0] rand_pc();
    logic [11:0] p;
    p = 12'($urandom_range(0, 4095));
    if (p == 12'h256) p = 12'h255;
    return p;
  endfunction

  // Outcome of a run from the rules: first of halt / budget ends it, an earlier
  // (or same-cycle) request drop aborts it with no ack.
  function automatic vec_t model(input logic [1:0] sel, input int halt_at,
                                 input bit use_pc, input int abort_at);
    vec_t v;
    bit   halted;
    int   end_k;
    halted     = (halt_at != 0) && (halt_at <= TO);
    end_k      = halted ? halt_at : TO;
    v.sel      = sel;
    v.halt_at  = halt_at;
    v.use_pc   = use_pc;
    v.abort_at = abort_at;
    v.exp_addr = ADDR_TAB[sel];
    if (abort_at != 0 && abort_at <= end_k) begin
      v.exp_ack   = 1'b0;
      v.exp_to    = 1'b0;
      v.exp_count = abort_at;
    end else begin
      v.exp_ack   = 1'b1;
      v.exp_to    = !halted;
      v.exp_count = end_k;
    end
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int hold;
    bus_if.req       = 1'b0;
    bus_if.halt_inst = 1'b0;
    bus_if.prog_ctr  = rand_pc();
    tick();
    bus_if.req      = 1'b1;
    bus_if.prog_sel = v.sel;
    tick();
    for (int i = 0; i < INIT_N; i++) begin
      chk({tag, " init core_init"}, 32'(bus_if.core_init), 32'd1);
      chk({tag, " init busy"}, 32'(bus_if.busy), 32'd1);
      chk({tag, " init start"}, 32'(bus_if.start), 32'd0);
      tick();
    end
    chk({tag, " launch start"}, 32'(bus_if.start), 32'd1);
    chk({tag, " launch core_init"}, 32'(bus_if.core_init), 32'd0);
    chk({tag, " start_addr"}, 32'(bus_if.start_addr), 32'(v.exp_addr));
    tick();
    for (int k = 1; k <= v.exp_count; k++) begin
      chk({tag, " run ack"}, 32'(bus_if.ack), 32'd0);
      chk({tag, " run busy"}, 32'(bus_if.busy), 32'd1);
      chk({tag, " run start"}, 32'(bus_if.start), 32'd0);
      if (k == v.halt_at) begin
        if (v.use_pc) bus_if.prog_ctr = 12'h256;
        else          bus_if.halt_inst = 1'b1;
      end else begin
        bus_if.prog_ctr  = rand_pc();
        bus_if.halt_inst = 1'b0;
      end
      if (k == v.abort_at) bus_if.req = 1'b0;
      tick();
    end
    bus_if.halt_inst = 1'b0;
    bus_if.prog_ctr  = rand_pc();
    if (v.exp_ack) begin
      chk({tag, " done ack"}, 32'(bus_if.ack), 32'd1);
      chk({tag, " done timeout"}, 32'(bus_if.timeout), 32'(v.exp_to));
      chk({tag, " done cycle_count"}, 32'(bus_if.cycle_count), 32'(v.exp_count));
      chk({tag, " done busy"}, 32'(bus_if.busy), 32'd1);
      hold = $urandom_range(1, 3);
      repeat (hold) begin
        tick();
        chk({tag, " hold ack"}, 32'(bus_if.ack), 32'd1);
        chk({tag, " hold timeout"}, 32'(bus_if.timeout), 32'(v.exp_to));
        chk({tag, " hold cycle_count"}, 32'(bus_if.cycle_count), 32'(v.exp_count));
      end
      bus_if.req = 1'b0;
      tick();
      chk({tag, " release ack"}, 32'(bus_if.ack), 32'd0);
      chk({tag, " release busy"}, 32'(bus_if.busy), 32'd0);
      chk({tag, " release cycle_count"}, 32'(bus_if.cycle_count), 32'(v.exp_count));
    end else begin
      chk({tag, " abort ack"}, 32'(bus_if.ack), 32'd0);
      chk({tag, " abort busy"}, 32'(bus_if.busy), 32'd0);
      chk({tag, " abort core_init"}, 32'(bus_if.core_init), 32'd0);
      chk({tag, " abort cycle_count"}, 32'(bus_if.cycle_count), 32'(v.exp_count));
      tick();
      chk({tag, " post-abort ack"}, 32'(bus_if.ack), 32'd0);
    end
    $display("run %s: sel=%0d halt_at=%0d abort_at=%0d -> ack=%0b timeout=%0b count=%0d",
             tag, v.sel, v.halt_at, v.abort_at, bus_if.ack, bus_if.timeout, bus_if.cycle_count);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " core_init"}, 32'(bus_if.core_init), 32'd0);
    chk({tag, " start"}, 32'(bus_if.start), 32'd0);
    chk({tag, " ack"}, 32'(bus_if.ack), 32'd0);
    chk({tag, " busy"}, 32'(bus_if.busy), 32'd0);
    chk({tag, " timeout"}, 32'(bus_if.timeout), 32'd0);
    chk({tag, " cycle_count"}, 32'(bus_if.cycle_count), 32'd0);
    chk({tag, " start_addr"}, 32'(bus_if.start_addr), 32'h000);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs [7];
    vec_t rv;

    vecs[0] = '{sel:2'd0, halt_at:40,  use_pc:1'b1, abort_at:0, exp_addr:12'h000, exp_ack:1'b1, exp_to:1'b0, exp_count:40};
    vecs[1] = '{sel:2'd2, halt_at:10,  use_pc:1'b0, abort_at:0, exp_addr:12'h200, exp_ack:1'b1, exp_to:1'b0, exp_count:10};
    vecs[2] = '{sel:2'd1, halt_at:0,   use_pc:1'b0, abort_at:0, exp_addr:12'h100, exp_ack:1'b1, exp_to:1'b1, exp_count:100};
    vecs[3] = '{sel:2'd3, halt_at:100, use_pc:1'b0, abort_at:0, exp_addr:12'h300, exp_ack:1'b1, exp_to:1'b0, exp_count:100};
    vecs[4] = '{sel:2'd1, halt_at:0,   use_pc:1'b0, abort_at:5, exp_addr:12'h100, exp_ack:1'b0, exp_to:1'b0, exp_count:5};
    vecs[5] = '{sel:2'd0, halt_at:1,   use_pc:1'b1, abort_at:0, exp_addr:12'h000, exp_ack:1'b1, exp_to:1'b0, exp_count:1};
    vecs[6] = '{sel:2'd3, halt_at:99,  use_pc:1'b1, abort_at:0, exp_addr:12'h300, exp_ack:1'b1, exp_to:1'b0, exp_count:99};

    init_n           = 1'b0;
    bus_if.req       = 1'b0;
    bus_if.prog_sel  = 2'd0;
    bus_if.prog_ctr  = 12'h000;
    bus_if.halt_inst = 1'b0;
    tick();
    chk_all_zero("reset");
    init_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("table%0d", i));
    end

    // Request withdrawn during INIT: back to IDLE with core_init dropped.
    bus_if.req = 1'b1;
    bus_if.prog_sel = 2'd2;
    tick();
    chk("init-abort entry core_init", 32'(bus_if.core_init), 32'd1);
    bus_if.req = 1'b0;
    tick();
    chk("init-abort core_init", 32'(bus_if.core_init), 32'd0);
    chk("init-abort busy", 32'(bus_if.busy), 32'd0);
    chk("init-abort ack", 32'(bus_if.ack), 32'd0);
    $display("seq init-abort: busy=%0b core_init=%0b", bus_if.busy, bus_if.core_init);

    // Reset pulsed mid-RUN with req held high through release.
    tick();
    bus_if.req = 1'b1;
    bus_if.prog_sel = 2'd3;
    repeat (INIT_N + 1 + 5) tick();
    chk("midrst pre busy", 32'(bus_if.busy), 32'd1);
    init_n = 1'b0;
    #1;
    chk_all_zero("midrst async");
    tick();
    tick();
    init_n = 1'b1;
    repeat (3) begin
      tick();
      chk("midrst held-req busy", 32'(bus_if.busy), 32'd0);
      chk("midrst held-req core_init", 32'(bus_if.core_init), 32'd0);
    end
    $display("seq mid-run reset: busy=%0b ack=%0b", bus_if.busy, bus_if.ack);
    run_vec(model(2'd1, 7, 1'b0, 0), "after-reset");

    for (int r = 0; r < 20; r++) begin
      logic [1:0] sel;
      int         h, a;
      bit         pc;
      sel = 2'($urandom_range(0, 3));
      h   = $urandom_range(0, 110);
      pc  = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 110) : 0;
      rv  = model(sel, h, pc, a);
      run_vec(rv, $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter HALT_ADDR, default 12'h256: program-counter value that marks program completion.
REQ-002 Parameter TIMEOUT_CYCLES, default 16'd4000: RUN-cycle budget before forced completion.
REQ-003 Parameter INIT_CYCLES, default 2: length of the core_init pulse, in cycles, range 1..15.
REQ-004 Parameter START_ADDR0..START_ADDR3, defaults 12'h000/12'h100/12'h200/12'h300: entry address per program select.
REQ-005 Clock and reset are decided: one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 init_n  in  1  asynchronous active-low reset.
REQ-008 req  in  1  bench request, four-phase level handshake with ack.
REQ-009 prog_sel  in  2  program index, sampled in IDLE when req=1.
REQ-010 prog_ctr  in  12  current program counter from the fetch unit.
REQ-011 halt_inst  in  1  decoder flag: the current instruction is a halt.
REQ-012 core_init  out  1  active-high reset to the datapath (regfile, data memory, fetch).
REQ-013 start  out  1  one-cycle pulse that loads start_addr into the fetch unit.
REQ-014 start_addr  out  12  entry address for the selected program.
REQ-015 ack  out  1  completion, held high until req falls.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 timeout  out  1  high with ack when completion was forced by TIMEOUT_CYCLES.
REQ-018 cycle_count  out  16  number of RUN cycles of the last or current run, saturating.

Function
REQ-019 States: IDLE, INIT, LAUNCH, RUN, DONE; all outputs are registered.
REQ-020 IDLE: when req=1, latch prog_sel, load start_addr from the table, clear cycle_count and timeout, load the init counter with INIT_CYCLES, then go to INIT.
REQ-021 INIT: core_init=1 for exactly INIT_CYCLES cycles, then go to LAUNCH.
REQ-022 LAUNCH: start=1 for exactly one cycle with core_init=0, then go to RUN.
REQ-023 RUN: increment cycle_count by 1 every cycle, saturating at 16'hFFFF.
REQ-024 In RUN, the FSM goes to DONE when prog_ctr==HALT_ADDR or halt_inst=1.
REQ-025 In RUN, when cycle_count reaches TIMEOUT_CYCLES-1 with no halt, set timeout=1 and go to DONE.
REQ-026 If a halt and a timeout occur in the same cycle, the halt wins and timeout=0.
REQ-027 ack rises in the first cycle of DONE, one cycle after the halt condition is sampled.
REQ-028 DONE: hold ack=1, timeout and cycle_count until req=0, then go to IDLE with ack=0 on the next edge.
REQ-029 If req falls in INIT, LAUNCH or RUN, abort to IDLE next cycle: no ack; cycle_count holds; core_init drops.
REQ-030 A new request is accepted only from IDLE; req held high after ack has fallen does not start a run until req has been low for at least one cycle.
REQ-031 start_addr holds its value between runs and never changes outside IDLE.

Reset
REQ-032 While init_n=0: state=IDLE; core_init, start, ack, busy and timeout are 0; cycle_count=0; start_addr=START_ADDR0.
REQ-033 An init_n assertion mid-run takes effect immediately with no ack; after release the FSM waits in IDLE for a fresh req rising.

Structure
REQ-034 Shared package prog_seq_pkg holds the state enum, the default HALT_ADDR and TIMEOUT_CYCLES values, and the START_ADDR table type.
REQ-035 A single sub-module, sat_counter (16-bit saturating counter with clear and enable), implements cycle_count; everything else is inline.

Verification
REQ-036 Reset, then req=1 with prog_sel=0 and prog_ctr reaching 12'h256 after 40 RUN cycles -> core_init is high for 2 cycles, start pulses once with start_addr=12'h000, ack=1, cycle_count=40, timeout=0.
REQ-037 prog_sel=2, halt_inst=1 in the 10th RUN cycle -> start_addr=12'h200, ack one cycle later, cycle_count=10.
REQ-038 No halt with TIMEOUT_CYCLES=100 -> ack=1, timeout=1, cycle_count=100; DONE holds while req=1 and returns to IDLE one cycle after req=0.
REQ-039 Halt and timeout in the same cycle -> ack=1, timeout=0.
REQ-040 req dropped in the 5th RUN cycle -> IDLE next cycle, ack never asserts, busy=0; a following req produces a normal run.
REQ-041 init_n pulsed low mid-RUN -> all outputs are 0 asynchronously; req held high through the reset release does not start a run until req toggles low then high.
